// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer: FSM state encoding and
// the selector that names where the next fetch address comes from.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_HOLD,
    ST_RUN
  } seq_state_e;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BRANCH,
    SRC_CALL,
    SRC_RET,
    SRC_HOLD
  } pc_src_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push onto a full stack silently overwrites
// the oldest entry, and the full/empty flags are registered from the updated count.
module ras_stack #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] pushData,
  output logic [WIDTH-1:0] topData,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] entries [RAS_DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    topPtr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    countNext;
  logic             doPop;

  assign topPtr  = wrPtr - PW'(1);
  assign topData = entries[topPtr];
  assign doPop   = pop && !push && (count != '0);

  // A push on a full stack keeps the count saturated; the pointer still
  // advances so the slot it lands on is always the oldest one.
  always_comb begin
    countNext = count;
    if (push) begin
      if (count != FULL_COUNT) begin
        countNext = count + CW'(1);
      end
    end else if (doPop) begin
      countNext = count - CW'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wrPtr <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PW'(1);
      end else if (doPop) begin
        wrPtr <= topPtr;
      end
      count <= countNext;
      full  <= (countNext == FULL_COUNT);
      empty <= (countNext == '0);
    end
  end

  always_ff @(posedge Clock) begin
    if (push) begin
      entries[wrPtr] <= pushData;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential step, branch, call/return through
// the RAS, stall, and wrap to the reset vector when the address leaves range.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] STEP       = WIDTH'(4),
  parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(0),
  parameter logic [WIDTH-1:0] LIMIT_ADDR = WIDTH'(248),
  parameter int               RAS_DEPTH  = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic             Call,
  input  logic             Return,
  output logic [WIDTH-1:0] PC,
  output logic             PCValid,
  output logic             Wrapped,
  output logic             RasFull,
  output logic             RasEmpty,
  output logic             RasErr
);

  seq_state_e       state;
  seq_state_e       nextState;
  pc_src_e          pcSrc;
  logic [WIDTH-1:0] pcSeq;
  logic [WIDTH-1:0] rasTop;
  logic [WIDTH-1:0] candidate;
  logic [WIDTH-1:0] pcNext;
  logic             wrapNext;
  logic             rasPush;
  logic             rasPop;
  logic             setErr;

  assign pcSeq = PC + STEP;

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .Clock    (Clock),
    .Reset    (Reset),
    .push     (rasPush),
    .pop      (rasPop),
    .pushData (pcSeq),
    .topData  (rasTop),
    .full     (RasFull),
    .empty    (RasEmpty)
  );

  // The HOLD cycle ignores controls but still steps, so fetch resumes at
  // RESET_ADDR+STEP straight after the one held cycle.
  always_comb begin
    nextState = state;
    pcSrc     = SRC_HOLD;
    rasPush   = 1'b0;
    rasPop    = 1'b0;
    setErr    = 1'b0;
    unique case (state)
      ST_RESET: begin
        nextState = ST_HOLD;
      end
      ST_HOLD: begin
        nextState = ST_RUN;
        pcSrc     = SRC_SEQ;
      end
      ST_RUN: begin
        if (Stall) begin
          pcSrc = SRC_HOLD;
        end else if (Return) begin
          if (!RasEmpty) begin
            pcSrc  = SRC_RET;
            rasPop = 1'b1;
          end else begin
            pcSrc  = SRC_SEQ;
            setErr = 1'b1;
          end
        end else if (Call) begin
          pcSrc   = SRC_CALL;
          rasPush = 1'b1;
        end else if (BranchTaken) begin
          pcSrc = SRC_BRANCH;
        end else begin
          pcSrc = SRC_SEQ;
        end
      end
      default: begin
        nextState = ST_RESET;
      end
    endcase
  end

  // Every candidate, including RAS pops, goes through the same range check.
  always_comb begin
    candidate = PC;
    unique case (pcSrc)
      SRC_SEQ:    candidate = pcSeq;
      SRC_BRANCH: candidate = BranchTarget;
      SRC_CALL:   candidate = BranchTarget;
      SRC_RET:    candidate = rasTop;
      SRC_HOLD:   candidate = PC;
      default:    candidate = PC;
    endcase
    wrapNext = (candidate > LIMIT_ADDR);
    pcNext   = wrapNext ? RESET_ADDR : candidate;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= ST_RESET;
      PC      <= RESET_ADDR;
      PCValid <= 1'b0;
      Wrapped <= 1'b0;
      RasErr  <= 1'b0;
    end else begin
      state   <= nextState;
      PC      <= pcNext;
      PCValid <= 1'b1;
      Wrapped <= wrapNext;
      if (setErr) begin
        RasErr <= 1'b1;
      end
    end
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised next-generation program counter for the ICARUS datapath. Holds the current instruction-fetch address and computes the next one internally: sequential increment, branch redirect, call/return through a small return-address stack (RAS), stall, and out-of-range wrap to the reset vector. Sits at the front of the fetch stage, driving instruction-memory address and accepting redirect controls from decode/execute.

## Interface

Parameters:
- WIDTH, 32, address width in bits
- STEP, 4, sequential increment in bytes
- RESET_ADDR, 0, reset vector and wrap destination
- LIMIT_ADDR, 248, highest legal fetch address
- RAS_DEPTH, 4, return-address stack entries, power of two, ≥2

Ports:
- Clock  in  1  single clock, rising edge
- Reset  in  1  synchronous, active-high
- Stall  in  1  hold PC and RAS this cycle
- BranchTaken  in  1  redirect to BranchTarget
- BranchTarget  in  WIDTH  redirect/call target
- Call  in  1  push PC+STEP, jump to BranchTarget
- Return  in  1  pop RAS top, jump to it
- PC  out  WIDTH  current fetch address (registered)
- PCValid  out  1  PC is a fetchable address this cycle
- Wrapped  out  1  one-cycle pulse: last update wrapped to RESET_ADDR
- RasFull  out  1  RAS holds RAS_DEPTH entries
- RasEmpty  out  1  RAS holds 0 entries
- RasErr  out  1  sticky: Return seen with empty RAS

## Operation

- States: RESET, HOLD, RUN.
- RESET: entered whenever Reset=1 at an edge, from any state. Outputs: PC=RESET_ADDR, PCValid=0, Wrapped=0, RasEmpty=1, RasFull=0, RasErr=0, RAS count=0.
- HOLD: first cycle after Reset deasserts. PC held at RESET_ADDR, PCValid=1, all control inputs ignored. Next state RUN unconditionally.
- RUN: candidate next PC by priority (highest first):
  - Stall=1: PC, RAS, RasErr unchanged; all other inputs ignored.
  - Return=1, RAS non-empty: next = popped top; count−1. Call/BranchTaken ignored.
  - Return=1, RAS empty: next = PC+STEP; RasErr←1. Call/BranchTaken ignored.
  - Call=1: push PC+STEP; next = BranchTarget. BranchTaken ignored.
  - BranchTaken=1: next = BranchTarget.
  - else: next = PC+STEP.
- Arithmetic: PC+STEP modulo 2^WIDTH; no carry out.
- Range check on final candidate, every path: if next > LIMIT_ADDR (unsigned), PC←RESET_ADDR and Wrapped=1 next cycle; else PC←next, Wrapped=0. Popped/pushed values are not range-checked at push time.
- RAS push when full: circular overwrite of oldest entry; count stays RAS_DEPTH; RasFull stays 1; no error.
- RasFull/RasEmpty reflect count after the update, registered.
- RasErr clears only on Reset.

## Timing

- All outputs registered; change only at rising Clock.
- Control inputs sampled at edge N take effect on PC at edge N (visible cycle N+1); latency 1.
- Reset asserted mid-operation: next cycle in RESET regardless of Stall/Call/Return; RAS contents discarded.
- Wrapped high exactly one cycle per wrap; consecutive wraps keep it high.
- PCValid: 0 only in RESET state.

## Structure

- Package pc_pkg: state encoding (RESET, HOLD, RUN), next-PC source select enum (SEQ, BRANCH, CALL, RET, HOLD).
- Sub-module ras_stack: circular LIFO, RAS_DEPTH × WIDTH, push/pop/count, full/empty flags, overwrite-oldest on full push, synchronous Reset clear.
- Top: FSM, priority mux, adder, range comparator.

## Test plan

- Reset 3 cycles, release, no controls -> PC 0,0 (PCValid 0), 0 (HOLD, PCValid 1), then 4, 8, 12 one per cycle.
- Free-run from 244 -> 248 then 0 with Wrapped=1 for one cycle, then 4 with Wrapped=0.
- PC=16, Call with target 100 -> PC=100, RasEmpty=0; then Return -> PC=20, RasEmpty=1.
- RAS_DEPTH=4: 5 Calls from PCs 0,40,80,120,160 (targets 40,80,120,160,200), then 5 Returns -> PCs 164,124,84,44, then 48 with RasErr=1 sticky.
- PC=32, Stall=1 with BranchTaken=1 target 200 for 2 cycles -> PC stays 32; Stall drop, no branch -> 36.
- Call+Return+BranchTaken same cycle with RAS top=60 -> PC=60, no push; Reset during Call -> PC=0, RasEmpty=1, RasErr=0.
